// File: rtl/pipe_latch_ctl.sv
// Inter-stage pipeline latch: NFIELDS x WIDTH payload plus valid, with stall hold,
// flush-to-bubble and saturating stall/bubble performance counters.
module pipe_latch_ctl #(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       NFIELDS   = 4,
  parameter int unsigned       INSTR_IDX = 1,
  parameter logic [WIDTH-1:0]  NOP_WORD  = '0,
  parameter int unsigned       CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NFIELDS*WIDTH-1:0]   data_in,
  input  logic                       valid_in,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       clear_counts,
  output logic [NFIELDS*WIDTH-1:0]   data_out,
  output logic                       valid_out,
  output logic [CNT_WIDTH-1:0]       stall_count,
  output logic [CNT_WIDTH-1:0]       bubble_count
);

  localparam int unsigned DW = NFIELDS * WIDTH;

  logic [DW-1:0] bubble_data;
  logic          stall_inc;
  logic          bubble_inc;

  // Bubble image: all fields zero except the instruction slot, which carries the NOP.
  always_comb begin
    bubble_data = '0;
    bubble_data[INSTR_IDX*WIDTH +: WIDTH] = NOP_WORD;
  end

  always_comb begin
    stall_inc  = stall && !flush;
    bubble_inc = flush || (!stall && !valid_in);
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      data_out  <= bubble_data;
      valid_out <= 1'b0;
    end else if (!stall) begin
      data_out  <= data_in;
      valid_out <= valid_in;
    end
  end

  // Clear beats a simultaneous increment; counters stick at all-ones.
  always_ff @(posedge clock) begin
    if (reset || clear_counts) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (stall_inc && (stall_count != '1))
        stall_count <= stall_count + CNT_WIDTH'(1);
      if (bubble_inc && (bubble_count != '1))
        bubble_count <= bubble_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipe_latch_ctl.sv
// Directed checks of pipe_latch_ctl in three parameterisations, plus a randomised
// run of a 6x16 instance against a behavioural reference model.
module tb_pipe_latch_ctl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Instance A: default parameters
  logic         a_reset = 1'b1, a_valid_in = 1'b0, a_stall = 1'b0, a_flush = 1'b0, a_clear = 1'b0;
  logic [127:0] a_data_in = '0, a_data_out;
  logic         a_valid_out;
  logic [15:0]  a_stall_count, a_bubble_count;

  pipe_latch_ctl u_dut_a (
    .clock(clock), .reset(a_reset), .data_in(a_data_in), .valid_in(a_valid_in),
    .stall(a_stall), .flush(a_flush), .clear_counts(a_clear),
    .data_out(a_data_out), .valid_out(a_valid_out),
    .stall_count(a_stall_count), .bubble_count(a_bubble_count)
  );

  // Instance B: NOP 0x13, 4-bit counters
  logic         b_reset = 1'b1, b_valid_in = 1'b0, b_stall = 1'b0, b_flush = 1'b0, b_clear = 1'b0;
  logic [127:0] b_data_in = '0, b_data_out;
  logic         b_valid_out;
  logic [3:0]   b_stall_count, b_bubble_count;

  pipe_latch_ctl #(.NOP_WORD(32'h0000_0013), .CNT_WIDTH(4)) u_dut_b (
    .clock(clock), .reset(b_reset), .data_in(b_data_in), .valid_in(b_valid_in),
    .stall(b_stall), .flush(b_flush), .clear_counts(b_clear),
    .data_out(b_data_out), .valid_out(b_valid_out),
    .stall_count(b_stall_count), .bubble_count(b_bubble_count)
  );

  // Instance C: 6 fields of 16 bits, instruction in field 3
  logic         c_reset = 1'b1, c_valid_in = 1'b0, c_stall = 1'b0, c_flush = 1'b0, c_clear = 1'b0;
  logic [95:0]  c_data_in = '0, c_data_out;
  logic         c_valid_out;
  logic [15:0]  c_stall_count, c_bubble_count;

  pipe_latch_ctl #(.WIDTH(16), .NFIELDS(6), .INSTR_IDX(3), .NOP_WORD(16'hA5A5)) u_dut_c (
    .clock(clock), .reset(c_reset), .data_in(c_data_in), .valid_in(c_valid_in),
    .stall(c_stall), .flush(c_flush), .clear_counts(c_clear),
    .data_out(c_data_out), .valid_out(c_valid_out),
    .stall_count(c_stall_count), .bubble_count(c_bubble_count)
  );

  logic [127:0] exp_a;
  logic [95:0]  c_bubble, m_data;
  logic         m_valid;
  logic [15:0]  m_stall, m_bubble;

  initial begin
    // ---------------- Instance A ----------------
    tick();
    check("a_rst_data", a_data_out, '0);
    check("a_rst_valid", a_valid_out, 0);
    check("a_rst_scnt", a_stall_count, 0);
    check("a_rst_bcnt", a_bubble_count, 0);

    a_reset = 1'b0;
    a_data_in = {32'd4, 32'd3, 32'h00A0_0020, 32'h0000_0010};
    a_valid_in = 1'b1;
    tick();
    check("a_load_data", a_data_out, {32'd4, 32'd3, 32'h00A0_0020, 32'h0000_0010});
    check("a_load_valid", a_valid_out, 1);
    check("a_load_bcnt", a_bubble_count, 0);

    a_data_in[31:0] = 32'h20;
    tick();
    check("a_pc20", a_data_out[31:0], 32'h20);

    a_stall = 1'b1;
    a_data_in[31:0] = 32'h24;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_stall_hold_pc", a_data_out[31:0], 32'h20);
    end
    check("a_stall_valid", a_valid_out, 1);
    check("a_stall_cnt3", a_stall_count, 3);

    a_stall = 1'b0;
    tick();
    check("a_release_pc", a_data_out[31:0], 32'h24);
    check("a_release_scnt", a_stall_count, 3);

    a_clear = 1'b1;
    tick();
    check("a_clear_scnt", a_stall_count, 0);
    check("a_clear_bcnt", a_bubble_count, 0);
    a_clear = 1'b0;

    a_valid_in = 1'b0;
    tick();
    tick();
    check("a_bub_valid", a_valid_out, 0);
    check("a_bub_bcnt2", a_bubble_count, 2);
    a_stall = 1'b1;
    a_valid_in = 1'b1;
    tick();
    tick();
    check("a_bubstall_bcnt", a_bubble_count, 2);
    check("a_bubstall_scnt", a_stall_count, 2);
    check("a_bubstall_valid", a_valid_out, 0);

    // ---------------- Instance B ----------------
    tick();
    b_reset = 1'b0;
    b_data_in = {32'hDEAD_BEEF, 32'h1234_5678, 32'h00A0_0020, 32'h0000_0040};
    b_valid_in = 1'b1;
    tick();
    check("b_load_data", b_data_out, {32'hDEAD_BEEF, 32'h1234_5678, 32'h00A0_0020, 32'h0000_0040});

    b_stall = 1'b1;
    b_flush = 1'b1;
    tick();
    check("b_flush_data", b_data_out, {32'h0, 32'h0, 32'h0000_0013, 32'h0});
    check("b_flush_valid", b_valid_out, 0);
    check("b_flush_bcnt", b_bubble_count, 1);
    check("b_flush_scnt", b_stall_count, 0);

    b_flush = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("b_sat_scnt", b_stall_count, 15);
    check("b_sat_bcnt", b_bubble_count, 1);
    check("b_sat_data", b_data_out, {32'h0, 32'h0, 32'h0000_0013, 32'h0});

    b_clear = 1'b1;
    tick();
    check("b_clr_scnt", b_stall_count, 0);
    check("b_clr_bcnt", b_bubble_count, 0);
    b_clear = 1'b0;
    tick();
    check("b_after_clr_scnt", b_stall_count, 1);

    b_stall = 1'b0;
    tick();
    check("b_reload", b_data_out, {32'hDEAD_BEEF, 32'h1234_5678, 32'h00A0_0020, 32'h0000_0040});
    check("b_reload_valid", b_valid_out, 1);

    b_stall = 1'b1;
    b_flush = 1'b1;
    b_reset = 1'b1;
    tick();
    check("b_rst_mid_data", b_data_out, {32'h0, 32'h0, 32'h0000_0013, 32'h0});
    check("b_rst_mid_valid", b_valid_out, 0);
    check("b_rst_mid_scnt", b_stall_count, 0);
    check("b_rst_mid_bcnt", b_bubble_count, 0);

    // ---------------- Instance C ----------------
    c_bubble = '0;
    c_bubble[63:48] = 16'hA5A5;
    tick();
    m_data = c_bubble; m_valid = 1'b0; m_stall = '0; m_bubble = '0;
    check("c_rst_data", c_data_out, c_bubble);
    c_reset = 1'b0;

    for (int cyc = 0; cyc < 1000; cyc++) begin
      c_reset    = ($urandom_range(63) == 0);
      c_flush    = ($urandom_range(7) == 0);
      c_stall    = ($urandom_range(3) == 0);
      c_clear    = ($urandom_range(31) == 0);
      c_valid_in = ($urandom_range(3) != 0);
      c_data_in  = {$urandom(), $urandom(), $urandom()};

      if (c_reset) begin
        m_data = c_bubble; m_valid = 1'b0; m_stall = '0; m_bubble = '0;
      end else begin
        if (c_clear) begin
          m_stall = '0;
          m_bubble = '0;
        end else begin
          if (c_stall && !c_flush && m_stall != 16'hFFFF) m_stall++;
          if ((c_flush || (!c_stall && !c_valid_in)) && m_bubble != 16'hFFFF) m_bubble++;
        end
        if (c_flush) begin
          m_data = c_bubble; m_valid = 1'b0;
        end else if (!c_stall) begin
          m_data = c_data_in; m_valid = c_valid_in;
        end
      end

      tick();
      check("c_data", c_data_out, m_data);
      check("c_valid", c_valid_out, m_valid);
      check("c_scnt", c_stall_count, m_stall);
      check("c_bcnt", c_bubble_count, m_bubble);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
